// File: rtl/mem_ctrl_if.sv
// Bus bundle between the MEM stage, the access controller and the byte-wide RAM.
// master: pipeline/RAM environment side. slave: the controller.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              mem_ce_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [3:0]        mem_sel_i;
  logic [31:0]       mem_data_i;
  logic [31:0]       mem_data_o;
  logic              mem_ready_o;
  logic              stall_req_o;
  logic              ram_en_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [7:0]        ram_wdata_o;
  logic [7:0]        ram_rdata_i;

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i, ram_rdata_i,
    input  mem_data_o, mem_ready_o, stall_req_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i, ram_rdata_i,
    output mem_data_o, mem_ready_o, stall_req_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// Data-memory access controller: serialises a 32-bit load/store with byte
// enables onto a byte-wide synchronous RAM, one selected lane per cycle in
// ascending order, and reassembles load bytes into a word.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, XFER, WAIT, DONE} state_t;

  state_t            state_reg, state_next;
  logic              we_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [3:0]        sel_reg;       // lanes still to be issued
  logic [31:0]       data_reg;
  logic [31:0]       asm_reg;       // load assembly word
  logic [1:0]        lane_reg;      // lane issued in the previous cycle
  logic              rd_pend_reg;   // a read byte arrives this cycle for lane_reg
  logic [31:0]       mem_data_reg;

  logic [1:0]        lane_cur;
  logic [3:0]        sel_left;
  logic [31:0]       asm_next;
  logic              accept;

  assign accept = bus.mem_ce_i && (bus.mem_sel_i != 4'b0000);

  // Lowest remaining lane is the one issued this cycle.
  always_comb begin
    lane_cur = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (sel_reg[i]) lane_cur = 2'(i);
    end
    sel_left = sel_reg & ~(4'b0001 << lane_cur);
  end

  // Merge the byte returned for the previously addressed lane.
  always_comb begin
    asm_next = asm_reg;
    if (rd_pend_reg) asm_next[{lane_reg, 3'b000} +: 8] = bus.ram_rdata_i;
  end

  // Next-state and output decode; RAM outputs are idle outside XFER.
  always_comb begin
    state_next      = state_reg;
    bus.stall_req_o = 1'b0;
    bus.mem_ready_o = 1'b0;
    bus.ram_en_o    = 1'b0;
    bus.ram_we_o    = 1'b0;
    bus.ram_addr_o  = '0;
    bus.ram_wdata_o = 8'h00;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          bus.stall_req_o = 1'b1;
          state_next      = XFER;
        end
      end
      XFER: begin
        bus.stall_req_o = 1'b1;
        bus.ram_en_o    = 1'b1;
        bus.ram_we_o    = we_reg;
        bus.ram_addr_o  = base_reg + ADDR_W'(lane_cur);
        if (we_reg) bus.ram_wdata_o = data_reg[{lane_cur, 3'b000} +: 8];
        if (sel_left == 4'b0000) state_next = we_reg ? DONE : WAIT;
      end
      WAIT: begin
        bus.stall_req_o = 1'b1;
        state_next      = DONE;
      end
      DONE: begin
        bus.mem_ready_o = 1'b1;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.mem_data_o = mem_data_reg;

  // State register plus request latching, lane stepping and load assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      we_reg       <= 1'b0;
      base_reg     <= '0;
      sel_reg      <= 4'b0000;
      data_reg     <= 32'h0;
      asm_reg      <= 32'h0;
      lane_reg     <= 2'd0;
      rd_pend_reg  <= 1'b0;
      mem_data_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            we_reg      <= bus.mem_we_i;
            base_reg    <= bus.mem_addr_i & ~ADDR_W'(3);
            sel_reg     <= bus.mem_sel_i;
            data_reg    <= bus.mem_data_i;
            asm_reg     <= 32'h0;
            rd_pend_reg <= 1'b0;
          end
        end
        XFER: begin
          sel_reg     <= sel_left;
          lane_reg    <= lane_cur;
          rd_pend_reg <= !we_reg;
          asm_reg     <= asm_next;
        end
        WAIT: begin
          asm_reg      <= asm_next;
          mem_data_reg <= asm_next;
          rd_pend_reg  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Data-memory access controller downstream of the MEM stage. It accepts one 32-bit load or store request at a time, with byte enables, and serialises it onto a byte-wide synchronous RAM port, one byte lane per cycle. It assembles load data back into a 32-bit word and asserts a stall request while the access is in flight, so the pipeline holds the MEM stage until completion.

## Interface
Parameters:
- ADDR_W, 32, width of request and RAM addresses.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_ce_i  in  1  request valid from MEM stage.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_addr_i  in  ADDR_W  request address; bits [1:0] ignored (word-aligned base).
- mem_sel_i  in  4  byte-lane enables; lane i = data bits [8i+7:8i], address base+i (little-endian).
- mem_data_i  in  32  store data.
- mem_data_o  out  32  load result; unselected lanes are 0.
- mem_ready_o  out  1  one-cycle pulse: request complete.
- stall_req_o  out  1  pipeline hold request.
- ram_en_o  out  1  RAM access strobe.
- ram_we_o  out  1  RAM write enable; valid only with ram_en_o.
- ram_addr_o  out  ADDR_W  RAM byte address.
- ram_wdata_o  out  8  RAM write byte.
- ram_rdata_i  in  8  RAM read byte; valid the cycle after the address cycle.

## Operation
- States: IDLE, XFER, WAIT, DONE.
- IDLE: if mem_ce_i=1 and mem_sel_i≠0, latch we, the base address {addr[ADDR_W-1:2],2'b00}, sel and data, and clear the read-assembly register. Go to XFER.
- IDLE with mem_ce_i=1 and mem_sel_i=0: no-op. No stall, no ready, no RAM activity.
- XFER: issue one RAM cycle per selected lane, in ascending lane order, skipping unselected lanes. Lane count n = popcount(sel), 1..4.
  - Store: ram_en_o=1, ram_we_o=1, ram_addr_o=base+i, ram_wdata_o=data[8i+7:8i].
  - Load: ram_en_o=1, ram_we_o=0, ram_addr_o=base+i. The byte returned the next cycle is written into lane i of the assembly register.
- After the last lane: a store goes to DONE; a load goes to WAIT, which captures the final byte, then to DONE.
- DONE: mem_ready_o=1 and stall_req_o=0. For loads, mem_data_o shows the assembled word. Always go to IDLE next; the same request is never re-accepted.
- mem_data_o is registered. It holds its value until the next load completes; stores do not change it.
- stall_req_o is combinational. It is 1 in XFER and WAIT, and in IDLE when mem_ce_i=1 and mem_sel_i≠0. Otherwise it is 0.
- Outside XFER: ram_en_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0.
- Misalignment is not detected; addr[1:0] is discarded.

## Timing
- Reset values: state IDLE; mem_data_o=0, mem_ready_o=0, ram_en_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0, lane counter 0. stall_req_o follows its IDLE equation.
- Cycle 0 is the IDLE cycle in which the request is sampled.
- Store: RAM cycles 1..n, DONE at cycle n+1. stall_req_o is high in cycles 0..n.
- Load: RAM address cycles 1..n, WAIT at n+1, DONE at n+2. stall_req_o is high in cycles 0..n+1.
- Address is presented in cycle k; ram_rdata_i is sampled at the end of cycle k+1.
- The pipeline advances at the edge ending DONE. A new request can be sampled in the IDLE cycle that follows, so there is one idle cycle between back-to-back requests.
- Inputs are only sampled in IDLE. Changes to mem_*_i during XFER, WAIT or DONE are ignored.
- Reset asserted mid-access: immediate return to IDLE with all outputs at their reset values. Bytes already written stay in RAM. No mem_ready_o pulse is produced.

## Test plan
- Word store: addr 0x1000, sel 1111, data 0xDEADBEEF. Expect RAM writes 0xEF@0x1000, 0xBE@0x1001, 0xAD@0x1002, 0xDE@0x1003 in cycles 1–4; mem_ready_o in cycle 5; stall high in cycles 0–4.
- Byte load: addr 0x2002, sel 0100, RAM returns 0x5A. Expect a single read at 0x2002 in cycle 1; mem_data_o=0x005A0000 and mem_ready_o in cycle 3.
- Sparse load: addr 0x3000, sel 1010, RAM bytes 0x11@0x3001 and 0x22@0x3003. Expect reads in cycles 1–2; mem_data_o=0x22001100 at DONE in cycle 4.
- No-op and back-to-back: ce=1 with sel=0 gives no stall and no RAM activity. Then a half store (addr 0x40, sel 0011, data 0x1234) immediately followed by a word load. Expect the second request accepted in the IDLE cycle after DONE, and mem_data_o unchanged by the store.
- Reset mid-store: a word store with rst_n low during cycle 2. Expect outputs at reset values immediately, only byte 0 written, no ready pulse. After release, a new request completes normally.
